ts_packet_scheduler_4ch: RTL
============================

# ts_packet_scheduler_4ch

Round-robin scheduler that shares one output byte stream between the four per-tuner reclock FIFOs. It watches each channel's `GOT_FULL_PACKET` and issues a one-cycle `GIVE_ME_ONE_PACKET` pulse to the selected channel. It then muxes that channel's 188-byte packet onto a single registered output stream with valid, sync and channel tag. It sits in the SYS_CLK domain between the four reclock stages and the downstream packet processor.

## Interface
- `PKT_LEN`, 188: bytes per packet; must match the FIFO-side read count.
- `RD_LATENCY`, 1: SYS_CLK cycles from a FIFO `rdreq` to valid data on `DATA_INn`.
- `GAP_CYCLES`, 4: idle cycles after each packet so FIFO `rdusedw` and `GOT_FULL_PACKET` settle; minimum 1.

Ports:
- `SYS_CLK` in 1: single clock.
- `RST` in 1: reset, asynchronous, active-low.
- `GOT_FULL_PACKET` in 4: bit n high means channel n holds at least one full packet.
- `DATA_IN0`..`DATA_IN3` in 8 each: FIFO `q` outputs of channels 0..3.
- `CH_EN` in 4: per-channel enable mask; a 0 bit excludes that channel from arbitration.
- `OUT_READY` in 1: downstream can accept a whole packet.
- `GIVE_ME_ONE_PACKET` out 4: one-hot, single-cycle read request to channel n.
- `DATA_OUT` out 8: output byte.
- `D_VALID_OUT` out 1: `DATA_OUT` valid.
- `P_SYNC_OUT` out 1: high with the first byte of each packet.
- `CH_ID` out 2: source channel of the current or last packet.
- `BUSY` out 1: high in every state except IDLE.
- `PKT_CNT` out 64: four 16-bit packet counters, channel n at [16n+15:16n]. See Configuration.

## Operation
- States: IDLE, WAIT, STREAM, GAP. `cnt` is an internal counter, at least 8 bits wide.
- **IDLE**
  - Eligibility: `req = GOT_FULL_PACKET & CH_EN`.
  - Grant condition: `OUT_READY` = 1 and `req` ≠ 0.
  - Channel selection: search `last+1`, `last+2`, `last+3`, `last+4` (mod 4) and pick the first set bit as `sel`.
  - On grant, registered at the next edge: `last` ← `sel`, `CH_ID` ← `sel`, `GIVE_ME_ONE_PACKET[sel]` ← 1, `cnt` ← 0, go to WAIT.
- **WAIT**
  - `GIVE_ME_ONE_PACKET` returns to 0 after exactly one cycle.
  - Stay RD_LATENCY+1 cycles, then `cnt` ← 0 and go to STREAM.
- **STREAM**
  - Each cycle: register `DATA_INsel` into `DATA_OUT`, set `D_VALID_OUT` ← 1, set `P_SYNC_OUT` ← (`cnt` == 0).
  - After the PKT_LEN-th byte (`cnt` == PKT_LEN-1), go to GAP.
- **GAP**
  - On the first cycle, the registers drop `D_VALID_OUT` to 0 and `P_SYNC_OUT` to 0.
  - Stay GAP_CYCLES cycles, then go to IDLE.
- Arbitration inputs:
  - `OUT_READY`, `CH_EN` and `GOT_FULL_PACKET` are sampled only in IDLE.
  - Deasserting any of them mid-packet does not abort the packet.
  - Clearing `CH_EN[sel]` mid-packet takes effect from the next IDLE.
- Simultaneous requests are resolved by the round-robin order only; there is no fixed priority.
- `DATA_OUT` holds its last value when `D_VALID_OUT` = 0.
- Asynchronous reset mid-packet returns to IDLE immediately. The output packet is truncated; the FIFO side is reset by the same `RST`.

## Timing
- Reset values:
  - State = IDLE, `last` = 3 (channel 0 wins first), `cnt` = 0.
  - `GIVE_ME_ONE_PACKET` = 0, `DATA_OUT` = 0, `D_VALID_OUT` = 0, `P_SYNC_OUT` = 0, `CH_ID` = 0, `BUSY` = 0, `PKT_CNT` = 0.
- Per-packet timeline, with grant sampled in IDLE at edge T-1:
  - `GIVE_ME_ONE_PACKET` is high during cycle T.
  - FIFO `rdreq` is high from T+1 to T+PKT_LEN.
  - Input data arrives from T+1+RD_LATENCY.
  - `D_VALID_OUT` is high from T+2+RD_LATENCY to T+1+RD_LATENCY+PKT_LEN.
  - `P_SYNC_OUT` is high in cycle T+2+RD_LATENCY.
- Packet period with continuous requests: 1 (IDLE) + RD_LATENCY+1 + PKT_LEN + GAP_CYCLES cycles, which is 195 at the defaults.

## Configuration
- `TS_SCHED_PKT_STAT_EN`
  - Defined: four 16-bit per-channel counters.
    - Increment: counter n increments when the last byte of a channel-n packet is registered (STREAM, `cnt` == PKT_LEN-1).
    - Wrap: 0xFFFF wraps to 0x0000.
    - Reset: cleared by `RST`.
  - Not defined: `PKT_CNT` is constant 0 and no counter logic is built. Ports are identical in both builds.

## Test plan
- Reset, then `GOT_FULL_PACKET`=4'b0001, `CH_EN`=4'hF, `OUT_READY`=1, ramp data 0x47,0x01..:
  - exactly one `GIVE_ME_ONE_PACKET`=4'b0001 pulse;
  - 188 valid bytes starting 0x47;
  - `P_SYNC_OUT` only on the first byte, 3 cycles after the pulse;
  - `CH_ID`=0.
- All four `GOT_FULL_PACKET` held high for 8 packets:
  - grant order 0,1,2,3,0,1,2,3;
  - period 195 cycles;
  - never two `GIVE_ME_ONE_PACKET` bits set.
- `CH_EN`=4'b1010 with all requests high:
  - only channels 1 and 3 are granted, alternating.
- `OUT_READY`=0 with requests pending:
  - no pulse and `BUSY`=0;
  - `OUT_READY` dropped at byte 50 of a packet → all 188 bytes are still delivered.
- `RST` asserted at byte 100:
  - all outputs go to their reset values asynchronously;
  - after release, the next grant goes to channel 0.
- With `TS_SCHED_PKT_STAT_EN`: after 3 channel-2 packets, `PKT_CNT[47:32]`=3 and all other counters 0.
  - Force channel 0's counter to 0xFFFF, send one channel-0 packet → it wraps to 0.
  - Without the macro: `PKT_CNT`=0 throughout.

Source files
------------

// File: rtl/ts_packet_scheduler_4ch.sv
// Round-robin packet scheduler: grants one of four reclock FIFOs a packet read and
// muxes its PKT_LEN bytes onto one registered stream. TS_SCHED_PKT_STAT_EN adds per-channel packet counters.
module ts_packet_scheduler_4ch #(
    parameter int PKT_LEN    = 188,
    parameter int RD_LATENCY = 1,
    parameter int GAP_CYCLES = 4
) (
    input  logic        SYS_CLK,
    input  logic        RST,
    input  logic [3:0]  GOT_FULL_PACKET,
    input  logic [7:0]  DATA_IN0,
    input  logic [7:0]  DATA_IN1,
    input  logic [7:0]  DATA_IN2,
    input  logic [7:0]  DATA_IN3,
    input  logic [3:0]  CH_EN,
    input  logic        OUT_READY,
    output logic [3:0]  GIVE_ME_ONE_PACKET,
    output logic [7:0]  DATA_OUT,
    output logic        D_VALID_OUT,
    output logic        P_SYNC_OUT,
    output logic [1:0]  CH_ID,
    output logic        BUSY,
    output logic [63:0] PKT_CNT
);
    localparam int CNT_W = ($clog2(PKT_LEN + 1) > 8) ? $clog2(PKT_LEN + 1) : 8;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STREAM, S_GAP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       last_q, sel, cand;
    logic [3:0]       req;
    logic             found, grant, last_byte;
    logic [7:0]       din_sel;

    assign req       = GOT_FULL_PACKET & CH_EN;
    assign grant     = (state_q == S_IDLE) && OUT_READY && (req != 4'd0);
    assign last_byte = (state_q == S_STREAM) && (cnt_q == CNT_W'(PKT_LEN - 1));
    assign BUSY      = (state_q != S_IDLE);

    // Search starts just after the last winner, so no channel has fixed priority.
    always_comb begin
        sel   = last_q;
        found = 1'b0;
        cand  = 2'd0;
        for (int i = 1; i < 5; i++) begin
            cand = last_q + 2'(i);
            if (!found && req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        case (CH_ID)
            2'd0:    din_sel = DATA_IN0;
            2'd1:    din_sel = DATA_IN1;
            2'd2:    din_sel = DATA_IN2;
            default: din_sel = DATA_IN3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (grant) begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: if (cnt_q == CNT_W'(RD_LATENCY)) begin
                state_d = S_STREAM;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            S_STREAM: if (last_byte) begin
                state_d = S_GAP;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        endcase
    end

    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            state_q            <= S_IDLE;
            cnt_q              <= '0;
            last_q             <= 2'd3;
            CH_ID              <= 2'd0;
            GIVE_ME_ONE_PACKET <= 4'd0;
            DATA_OUT           <= 8'd0;
            D_VALID_OUT        <= 1'b0;
            P_SYNC_OUT         <= 1'b0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            GIVE_ME_ONE_PACKET <= grant ? (4'd1 << sel) : 4'd0;
            if (grant) begin
                last_q <= sel;
                CH_ID  <= sel;
            end
            // DATA_OUT only loads while streaming, so it holds between packets.
            if (state_q == S_STREAM) begin
                DATA_OUT    <= din_sel;
                D_VALID_OUT <= 1'b1;
                P_SYNC_OUT  <= (cnt_q == '0);
            end else begin
                D_VALID_OUT <= 1'b0;
                P_SYNC_OUT  <= 1'b0;
            end
        end
    end

`ifdef TS_SCHED_PKT_STAT_EN
    logic [63:0] pkt_cnt_q;

    for (genvar g = 0; g < 4; g++) begin : g_stat
        always_ff @(posedge SYS_CLK or negedge RST) begin
            if (!RST)
                pkt_cnt_q[16*g +: 16] <= 16'd0;
            else if (last_byte && (CH_ID == 2'(g)))
                pkt_cnt_q[16*g +: 16] <= pkt_cnt_q[16*g +: 16] + 16'd1;
        end
    end

    assign PKT_CNT = pkt_cnt_q;
`else
    assign PKT_CNT = 64'd0;
`endif

endmodule
